// File: rtl/core_pkg.sv
// Shared definitions for the datapath stages: the machine word width and its
// typedef, the output-port pacing state encoding, and a helper that sizes
// down-counters.
package core_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic {
      PACE_IDLE = 1'b0,
      PACE_WAIT = 1'b1
   } pace_state_t;

   // Bits needed to hold the values 0..n. Returns at least 1 so that a
   // counter for n == 0 still has a legal width.
   function automatic int ctr_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO.
// Storage is a DEPTH x WIDTH array. The write and read pointers are
// log2(DEPTH) bits wide and wrap from DEPTH-1 back to 0 on their own.
// Occupancy is kept in a separate counter, so full and empty can be told
// apart when the two pointers are equal.
// The caller must not push while full or pop while empty.
// Ports:
//   clk, n_rst    clock, asynchronous active-low reset
//   push, wr_data write wr_data at the tail on this edge
//   pop           drop the head entry on this edge
//   rd_data       head entry, read combinationally
//   count         number of occupied entries
//   full, empty   decoded from count
module sync_fifo
   import core_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // The array is not reset. Its contents are only observed through
   // rd_data, and rd_data is ignored while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/out_port.sv
// Output port for OUT instructions.
// Words from the issuing stage are buffered in a small FIFO. They are handed
// to the output device over a valid/ready handshake, with an optional
// minimum number of idle cycles between transfers.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   PACE_IDLE | gap_cnt == 0; dev_valid follows FIFO non-empty
//   PACE_WAIT | gap_cnt counting GAP..1 after a transfer; dev_valid held low
//
// Ports:
//   clk, n_rst  clock, asynchronous active-low reset
//   out_en      OUT instruction valid this cycle (already flush-qualified)
//   out_dat     word to output
//   out_stall   pipeline must hold the OUT instruction
//   dev_valid   dev_dat holds a word for the device
//   dev_dat     head-of-FIFO word
//   dev_ready   device accepts the word this cycle
//   count       occupied FIFO entries
//   empty       FIFO holds no words
module out_port
   import core_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int DEPTH = 4,
   parameter int GAP   = 0
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       out_en,
   input  logic [WIDTH-1:0]           out_dat,
   output logic                       out_stall,
   output logic                       dev_valid,
   output logic [WIDTH-1:0]           dev_dat,
   input  logic                       dev_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);

   localparam int GAP_W = ctr_w(GAP);

   logic             full;
   logic             push;
   logic             pop;
   pace_state_t      state;
   logic [GAP_W-1:0] gap_cnt;

   // full comes from registered occupancy only. A pop on this same edge
   // does not release the stall; the instruction retries next cycle.
   assign out_stall = out_en & full;
   assign push      = out_en & ~full;
   assign dev_valid = ~empty & (gap_cnt == '0);
   assign pop       = dev_valid & dev_ready;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .push    (push),
      .wr_data (out_dat),
      .pop     (pop),
      .rd_data (dev_dat),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state   <= PACE_IDLE;
         gap_cnt <= '0;
      end else begin
         case (state)
            PACE_IDLE: begin
               if (pop && (GAP > 0)) begin
                  state   <= PACE_WAIT;
                  gap_cnt <= GAP_W'(GAP);
               end
            end
            PACE_WAIT: begin
               gap_cnt <= gap_cnt - GAP_W'(1);
               if (gap_cnt == GAP_W'(1)) begin
                  state <= PACE_IDLE;
               end
            end
            default: begin
               state   <= PACE_IDLE;
               gap_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_out_port.sv
// Bench for out_port. Two instances share the same stimulus: dut_a runs
// back-to-back (GAP=0) and dut_b uses GAP=2. Each instance is compared
// every cycle against a queue-based model of the port.
module tb_out_port;

   localparam int W     = 16;
   localparam int D     = 4;
   localparam int GAP_B = 2;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          out_en;
   logic [W-1:0]  out_dat;
   logic          dev_ready;

   logic          stall_a, valid_a, empty_a;
   logic [W-1:0]  dat_a;
   logic [2:0]    count_a;
   logic          stall_b, valid_b, empty_b;
   logic [W-1:0]  dat_b;
   logic [2:0]    count_b;

   out_port #(.WIDTH(W), .DEPTH(D), .GAP(0)) dut_a (
      .clk(clk), .n_rst(n_rst), .out_en(out_en), .out_dat(out_dat),
      .out_stall(stall_a), .dev_valid(valid_a), .dev_dat(dat_a),
      .dev_ready(dev_ready), .count(count_a), .empty(empty_a)
   );

   out_port #(.WIDTH(W), .DEPTH(D), .GAP(GAP_B)) dut_b (
      .clk(clk), .n_rst(n_rst), .out_en(out_en), .out_dat(out_dat),
      .out_stall(stall_b), .dev_valid(valid_b), .dev_dat(dat_b),
      .dev_ready(dev_ready), .count(count_b), .empty(empty_b)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: a word queue per instance. For dut_b, gap_b is the
   // number of idle cycles still owed after the last transfer.
   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];
   int           gap_b = 0;

   typedef struct {
      logic         en;
      logic [W-1:0] dat;
      logic         rdy;
      logic         exp_valid;
      logic [W-1:0] exp_dat;
      logic         exp_stall;
      logic [2:0]   exp_count;
   } vec_t;

   vec_t vt[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Called just after a falling edge with the inputs already driven.
   // Compares both instances against the model, then advances the model
   // across the next rising edge.
   task automatic tick();
      bit ev_a, ev_b, push_a, push_b, pop_a, pop_b;
      #1;
      ev_a = (qa.size() > 0);
      ev_b = (qb.size() > 0) && (gap_b == 0);
      chk("a_valid", 32'(valid_a), 32'(ev_a));
      if (ev_a) chk("a_dat", 32'(dat_a), 32'(qa[0]));
      chk("a_count", 32'(count_a), qa.size());
      chk("a_empty", 32'(empty_a), 32'(qa.size() == 0));
      chk("a_stall", 32'(stall_a), 32'(out_en && qa.size() == D));
      chk("b_valid", 32'(valid_b), 32'(ev_b));
      if (ev_b) chk("b_dat", 32'(dat_b), 32'(qb[0]));
      chk("b_count", 32'(count_b), qb.size());
      chk("b_empty", 32'(empty_b), 32'(qb.size() == 0));
      chk("b_stall", 32'(stall_b), 32'(out_en && qb.size() == D));
      push_a = out_en && (qa.size() < D);
      push_b = out_en && (qb.size() < D);
      pop_a  = ev_a && dev_ready;
      pop_b  = ev_b && dev_ready;
      @(posedge clk);
      if (pop_a) void'(qa.pop_front());
      if (push_a) qa.push_back(out_dat);
      if (pop_b) begin
         void'(qb.pop_front());
         gap_b = GAP_B;
      end else if (gap_b > 0) begin
         gap_b--;
      end
      if (push_b) qb.push_back(out_dat);
      @(negedge clk);
   endtask

   task automatic drain();
      out_en    = 1'b0;
      dev_ready = 1'b1;
      for (int k = 0; k < 30 && !(qa.size() == 0 && qb.size() == 0 && gap_b == 0); k++) tick();
      chk("drain_a", 32'(qa.size()), 0);
      chk("drain_b", 32'(qb.size() + gap_b), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] popped[$];
      int           pulses[$];
      logic         hold_a, hold_b;
      logic [W-1:0] prev_a, prev_b;

      vt[0]  = '{1'b1, 16'h00A5, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0};
      vt[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A5, 1'b0, 3'd1};
      vt[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0};
      vt[3]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0};
      vt[4]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 16'h0001, 1'b0, 3'd1};
      vt[5]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 16'h0001, 1'b0, 3'd2};
      vt[6]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 16'h0001, 1'b0, 3'd3};
      vt[7]  = '{1'b1, 16'h0005, 1'b0, 1'b1, 16'h0001, 1'b1, 3'd4};
      vt[8]  = '{1'b1, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 3'd4};
      vt[9]  = '{1'b1, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b0, 3'd3};
      vt[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b0, 3'd4};
      vt[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 1'b0, 3'd3};
      vt[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b0, 3'd2};
      vt[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005, 1'b0, 3'd1};
      vt[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0};

      n_rst     = 1'b0;
      out_en    = 1'b0;
      out_dat   = '0;
      dev_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid_a", 32'(valid_a), 0);
      chk("rst_empty_a", 32'(empty_a), 1);
      chk("rst_count_b", 32'(count_b), 0);
      @(negedge clk);
      n_rst = 1'b1;

      // Single word, then fill to full, stall, release, drain.
      for (int i = 0; i < 15; i++) begin
         out_en    = vt[i].en;
         out_dat   = vt[i].dat;
         dev_ready = vt[i].rdy;
         #1;
         chk($sformatf("vec%0d_valid", i), 32'(valid_a), 32'(vt[i].exp_valid));
         chk($sformatf("vec%0d_count", i), 32'(count_a), 32'(vt[i].exp_count));
         chk($sformatf("vec%0d_stall", i), 32'(stall_a), 32'(vt[i].exp_stall));
         chk($sformatf("vec%0d_empty", i), 32'(empty_a), 32'(vt[i].exp_count == 3'd0));
         if (vt[i].exp_valid) chk($sformatf("vec%0d_dat", i), 32'(dat_a), 32'(vt[i].exp_dat));
         tick();
      end

      // Simultaneous push and pop at count 2; pointers wrap several times.
      drain();
      dev_ready = 1'b0;
      out_en    = 1'b1;
      for (int k = 0; k < 2; k++) begin
         out_dat = 16'h0010 + 16'(k);
         tick();
      end
      dev_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         out_dat = 16'h0012 + 16'(k);
         #1;
         chk("pp_count_a", 32'(count_a), 2);
         if (valid_a) popped.push_back(dat_a);
         tick();
      end
      chk("pp_popped_n", popped.size(), 6);
      foreach (popped[k]) chk("pp_order", 32'(popped[k]), 32'(16'h0010 + 16'(k)));

      // Pacing on the GAP=2 instance: three queued words, device always ready.
      drain();
      dev_ready = 1'b0;
      out_en    = 1'b1;
      for (int k = 0; k < 3; k++) begin
         out_dat = 16'h0021 + 16'(k);
         tick();
      end
      out_en    = 1'b0;
      dev_ready = 1'b1;
      popped.delete();
      for (int c = 0; c < 9; c++) begin
         #1;
         if (valid_b) begin
            pulses.push_back(c);
            popped.push_back(dat_b);
         end
         tick();
      end
      chk("gap_pulses", pulses.size(), 3);
      if (pulses.size() == 3) begin
         chk("gap_t0", pulses[0], 0);
         chk("gap_t3", pulses[1], 3);
         chk("gap_t6", pulses[2], 6);
         foreach (popped[k]) chk("gap_order", 32'(popped[k]), 32'(16'h0021 + 16'(k)));
      end

      // Asynchronous reset between edges with two words held.
      drain();
      dev_ready = 1'b0;
      out_en    = 1'b1;
      for (int k = 0; k < 2; k++) begin
         out_dat = 16'h0031 + 16'(k);
         tick();
      end
      out_en = 1'b0;
      #2;
      n_rst = 1'b0;
      #1;
      chk("arst_valid_a", 32'(valid_a), 0);
      chk("arst_count_a", 32'(count_a), 0);
      chk("arst_empty_a", 32'(empty_a), 1);
      chk("arst_valid_b", 32'(valid_b), 0);
      chk("arst_count_b", 32'(count_b), 0);
      chk("arst_empty_b", 32'(empty_b), 1);
      qa.delete();
      qb.delete();
      gap_b = 0;
      @(negedge clk);
      n_rst     = 1'b1;
      dev_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("post_rst_valid_a", 32'(valid_a), 0);
         tick();
      end

      // Random traffic with random backpressure.
      hold_a = 1'b0;
      hold_b = 1'b0;
      prev_a = '0;
      prev_b = '0;
      for (int c = 0; c < 200; c++) begin
         out_en    = 1'($urandom_range(0, 1));
         out_dat   = 16'($urandom);
         dev_ready = 1'($urandom_range(0, 1));
         #1;
         if (hold_a) chk("hold_a", {15'd0, valid_a, dat_a}, {15'd0, 1'b1, prev_a});
         if (hold_b) chk("hold_b", {15'd0, valid_b, dat_b}, {15'd0, 1'b1, prev_b});
         chk("count_a_max", 32'(count_a <= 3'd4), 1);
         hold_a = valid_a && !dev_ready;
         hold_b = valid_b && !dev_ready;
         prev_a = dat_a;
         prev_b = dat_b;
         tick();
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
